// File: rtl/piezo_pkg.sv
// Shared types and constants for the piezo alert-tune scheduler.
package piezo_pkg;

  typedef enum logic [2:0] {
    NOTE_SIL = 3'd0,
    NOTE_G6  = 3'd1,
    NOTE_C7  = 3'd2,
    NOTE_E7  = 3'd3,
    NOTE_G7  = 3'd4
  } note_t;

  // Duration codes: 2^22, 2^23, 2^23+2^22, 2^25 cycles.
  typedef enum logic [1:0] {
    DUR_22    = 2'd0,
    DUR_23    = 2'd1,
    DUR_23_22 = 2'd2,
    DUR_25    = 2'd3
  } dur_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    STEER = 2'd1,
    BATT  = 2'd2,
    FAST  = 2'd3
  } tune_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    PLAY  = 2'd2
  } sched_state_t;

  localparam int unsigned STEER_LEN = 6;
  localparam int unsigned BATT_LEN  = 6;
  localparam int unsigned FAST_LEN  = 3;
  localparam int unsigned TIMER_W   = 28;

endpackage

// File: rtl/piezo_sched_if.sv
// Note handshake between the scheduler (master) and the tone generator (slave).
interface piezo_sched_if;
  logic       note_vld;
  logic       note_rdy;
  logic       note_done;
  logic [2:0] note;
  logic [1:0] dur_sel;

  modport master (
    output note_vld, note, dur_sel,
    input  note_rdy, note_done
  );

  modport slave (
    input  note_vld, note, dur_sel,
    output note_rdy, note_done
  );
endinterface

// File: rtl/piezo_sched_tune_rom.sv
// Tune ROM: (tune, step index) -> (note, duration, last-step flag).
module tune_rom
  import piezo_pkg::*;
(
  input  tune_t      tune,
  input  logic [2:0] idx,
  output note_t      note,
  output dur_t       dur,
  output logic       last
);

  // Pure lookup; out-of-range steps read as silence flagged last.
  always_comb begin
    note = NOTE_SIL;
    dur  = DUR_22;
    last = 1'b1;
    case (tune)
      STEER: begin
        last = (idx == 3'(STEER_LEN - 1));
        case (idx)
          3'd0: begin note = NOTE_G6; dur = DUR_23;    end
          3'd1: begin note = NOTE_C7; dur = DUR_23;    end
          3'd2: begin note = NOTE_E7; dur = DUR_23;    end
          3'd3: begin note = NOTE_G7; dur = DUR_23_22; end
          3'd4: begin note = NOTE_E7; dur = DUR_22;    end
          3'd5: begin note = NOTE_G7; dur = DUR_25;    end
          default: last = 1'b1;
        endcase
      end
      BATT: begin
        last = (idx == 3'(BATT_LEN - 1));
        case (idx)
          3'd0: begin note = NOTE_G7; dur = DUR_25;    end
          3'd1: begin note = NOTE_E7; dur = DUR_22;    end
          3'd2: begin note = NOTE_G7; dur = DUR_23_22; end
          3'd3: begin note = NOTE_E7; dur = DUR_23;    end
          3'd4: begin note = NOTE_C7; dur = DUR_23;    end
          3'd5: begin note = NOTE_G6; dur = DUR_23;    end
          default: last = 1'b1;
        endcase
      end
      FAST: begin
        last = (idx == 3'(FAST_LEN - 1));
        case (idx)
          3'd0: begin note = NOTE_G6; dur = DUR_23; end
          3'd1: begin note = NOTE_C7; dur = DUR_23; end
          3'd2: begin note = NOTE_E7; dur = DUR_23; end
          default: last = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/piezo_sched.sv
// Alert-tune scheduler: arbitrates too_fast/batt_low/en_steer, enforces the
// repeat interval and feeds one note at a time to the tone generator.
//
// state | meaning
// IDLE  | no tune active; waiting for a request (and timer expiry unless too_fast)
// ISSUE | offering the current step's note on the handshake
// PLAY  | note accepted; waiting for note_done from the tone generator
module piezo_sched
  import piezo_pkg::*;
#(
  parameter bit          fast_sim   = 1'b1,
  parameter int unsigned REPEAT_CNT = 150_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 too_fast,
  input  logic                 batt_low,
  input  logic                 en_steer,
  piezo_sched_if.master        note_bus,
  output logic [1:0]           tune_id,
  output logic                 busy
);

  localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(REPEAT_CNT);
  localparam logic [TIMER_W-1:0] STEP   = fast_sim ? TIMER_W'(64) : TIMER_W'(1);

  sched_state_t       state;
  tune_t              tune_q;
  logic [2:0]         idx_q;
  logic               last_q;
  logic [TIMER_W-1:0] timer_q;

  tune_t      nxt_tune;
  logic [2:0] nxt_idx;
  logic       go_issue;
  logic       reload;
  logic       to_idle;
  logic       expired;

  note_t rom_note;
  dur_t  rom_dur;
  logic  rom_last;

  assign expired = (timer_q == '0);
  assign tune_id = tune_q;

  // The ROM is addressed with the step about to be issued so note/dur can be
  // registered on the same edge that enters ISSUE.
  tune_rom u_rom (
    .tune (nxt_tune),
    .idx  (nxt_idx),
    .note (rom_note),
    .dur  (rom_dur),
    .last (rom_last)
  );

  // Next-step selection: arbitration in IDLE, advance/preempt/loop in PLAY.
  always_comb begin
    nxt_tune = tune_q;
    nxt_idx  = idx_q;
    go_issue = 1'b0;
    reload   = 1'b0;
    to_idle  = 1'b0;
    case (state)
      IDLE: begin
        if (too_fast) begin
          nxt_tune = FAST;  nxt_idx = 3'd0; go_issue = 1'b1; reload = 1'b1;
        end else if (expired && batt_low) begin
          nxt_tune = BATT;  nxt_idx = 3'd0; go_issue = 1'b1; reload = 1'b1;
        end else if (expired && en_steer) begin
          nxt_tune = STEER; nxt_idx = 3'd0; go_issue = 1'b1; reload = 1'b1;
        end
      end
      PLAY: begin
        if (note_bus.note_done) begin
          if (too_fast && tune_q != FAST) begin
            nxt_tune = FAST; nxt_idx = 3'd0; go_issue = 1'b1; reload = 1'b1;
          end else if (!last_q) begin
            nxt_idx = idx_q + 3'd1; go_issue = 1'b1;
          end else if (tune_q == FAST && too_fast) begin
            nxt_idx = 3'd0; go_issue = 1'b1;
          end else begin
            to_idle = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Scheduler FSM, registered outputs and saturating repeat timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      tune_q           <= NONE;
      idx_q            <= 3'd0;
      last_q           <= 1'b0;
      timer_q          <= '0;
      busy             <= 1'b0;
      note_bus.note_vld <= 1'b0;
      note_bus.note     <= '0;
      note_bus.dur_sel  <= '0;
    end else begin
      if (reload)
        timer_q <= RELOAD;
      else if (timer_q >= STEP)
        timer_q <= timer_q - STEP;
      else
        timer_q <= '0;

      case (state)
        IDLE, PLAY: begin
          if (go_issue) begin
            state             <= ISSUE;
            tune_q            <= nxt_tune;
            idx_q             <= nxt_idx;
            last_q            <= rom_last;
            busy              <= 1'b1;
            note_bus.note_vld <= 1'b1;
            note_bus.note     <= rom_note;
            note_bus.dur_sel  <= rom_dur;
          end else if (to_idle) begin
            state  <= IDLE;
            tune_q <= NONE;
            idx_q  <= 3'd0;
            busy   <= 1'b0;
          end
        end
        ISSUE: begin
          if (note_bus.note_rdy) begin
            state             <= PLAY;
            note_bus.note_vld <= 1'b0;
            note_bus.note     <= '0;
            note_bus.dur_sel  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
